pulse_stretcher: RTL and testbench
==================================

# pulse_stretcher

Multi-channel output conditioner: each active-going edge on a channel input produces an output pulse of guaranteed minimum width, followed by a guaranteed minimum idle gap. It is the output-side counterpart of the input debouncer. The debouncer suppresses short input activity; this block guarantees that short internal events become output pulses long enough for slow external consumers (LEDs, relays, off-chip logic). It sits between core logic and the output pad registers.

## Interface
- `DATA_W`, 8: number of independent channels.
- `CNT_W`, 8: width of the hold/gap length inputs and the per-channel counters.
- `IDLE_VAL`, 0: inactive output level, applied to every bit; the active level is `!IDLE_VAL`.
- `clk` input 1: the single clock; all logic is posedge.
- `rst` input 1: reset, asynchronous, active-high.
- `hold_cycles` input `CNT_W`: active pulse width is `hold_cycles+1` cycles.
- `gap_cycles` input `CNT_W`: minimum idle time between pulses is `gap_cycles+1` cycles.
- `data_in` input `DATA_W`: event inputs, one per channel; single-cycle pulses are allowed.
- `data_out` output `DATA_W`: stretched pulses, registered.
- `busy` output `DATA_W`: high while a channel is in HOLD or GAP, registered.

## Operation
- Per-channel FSM with three states: IDLE, HOLD, GAP. Also per channel: a `prev` input register, a `cnt` counter (`CNT_W` bits) and a `pending` flag.
- Edge definition: `edge = (data_in != IDLE_VAL) && (prev == IDLE_VAL)`. `prev <= data_in` every cycle.
- IDLE:
  - On `edge`: go to HOLD, set `cnt<=0`, `data_out<=!IDLE_VAL`.
  - Otherwise: no change.
- HOLD:
  - If `cnt >= hold_cycles`: go to GAP, set `cnt<=0`, `data_out<=IDLE_VAL`.
  - Otherwise: `cnt<=cnt+1`.
  - An `edge` in HOLD sets `pending`, unless `RETRIGGER_EN` is defined (see Configuration).
- GAP:
  - An `edge` sets `pending`.
  - If `cnt >= gap_cycles`: if `pending` (or `edge` in this same cycle), clear `pending` and enter HOLD with `cnt<=0`, `data_out<=!IDLE_VAL`; otherwise go to IDLE.
  - Otherwise: `cnt<=cnt+1`.
- `pending` is one bit. Any number of edges during HOLD/GAP collapse into exactly one follow-up pulse.
- `busy = (state != IDLE)`, updated in the same cycle as the state.
- Counter comparisons use the live `hold_cycles`/`gap_cycles` values with `>=`. Lowering a length mid-pulse ends the phase at the next cycle. Raising it extends the phase. `cnt` never wraps, because it stops at the compare value.
- Illegal state encoding: return to IDLE with outputs at their reset values and `pending` cleared.

## Timing
- Reset values: `data_out={DATA_W{IDLE_VAL}}`, `busy=0`, state IDLE, `cnt=0`, `pending=0`, `prev={DATA_W{IDLE_VAL}}`.
- Latency: an edge sampled at clock N drives `data_out` active from clock N+1.
- Pulse width is exactly `hold_cycles+1` cycles; the idle gap is at least `gap_cycles+1` cycles.
- With `hold_cycles=0`, `gap_cycles=0`: maximum rate is a 1-cycle pulse every 2 cycles.
- An input held active after reset release produces one pulse, because `prev` resets to `IDLE_VAL`.
- A level held active produces only one pulse; a new pulse requires a return to idle and another edge.
- Asserting `rst` mid-pulse forces outputs to their reset values immediately (asynchronous). No pulse resumes after release, except under the held-active rule above.
- Channels are fully independent; simultaneous edges on several channels are each handled in the same cycle.

## Configuration
- `PULSE_STRETCHER_RETRIGGER_EN` defined: an `edge` in HOLD resets `cnt<=0`, keeping `data_out` active. The pulse then ends `hold_cycles+1` cycles after the last edge. `pending` is not set from HOLD. Edges in GAP still set `pending`.
- Not defined: behaviour as in Operation. HOLD length is fixed, and HOLD edges set `pending`.

## Structure
- Package `pulse_stretcher_pkg` contains:
  - the state enum typedef `ps_state_t` (IDLE, HOLD, GAP; 2-bit logic encoding);
  - the active-level helper constant derived from `IDLE_VAL`, or a function computing it.
- Sub-module `pulse_stretch_chan`: a single channel holding the FSM, `cnt`, `pending` and `prev`. It is parameterised on `CNT_W` and `IDLE_VAL`.
- The top level replicates `pulse_stretch_chan` `DATA_W` times in a generate loop.

## Test plan
- Single event: `hold=3`, `gap=2`; a 1-cycle pulse on ch0 at cycle 10 -> `data_out[0]` active cycles 11–14, `busy[0]` high 11–17, idle from 18.
- Event during HOLD: `hold=3`, `gap=2`; edges at 10 and 12 -> pulses at 11–14 and 18–21. With `RETRIGGER_EN`: a single pulse 11–16, with no second pulse.
- Burst collapse: `hold=1`, `gap=4`; edges at 10, 12, 14 -> exactly two pulses, 11–12 and 18–19.
- Minimum settings: `hold=0`, `gap=0`; `data_in` toggling every cycle -> 1-cycle pulses every 2 cycles, and no two adjacent active cycles.
- Reset mid-pulse: `hold=10`; an edge at 10, then `rst` asserted at cycle 13 between edges -> `data_out` idle immediately. After release with input idle, there is no further activity.
- `IDLE_VAL=1`, `DATA_W=4`: simultaneous falling edges on all channels -> all `data_out` bits go low together for `hold+1` cycles.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// ============================================================================
// pulse_stretcher_pkg : shared state encoding and active-level helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pulse_stretcher_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_GAP  = 2'd2
   } ps_state_t;

   function automatic logic active_level(input logic idle_val);
      return ~idle_val;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_stretch_chan.sv
// ============================================================================
// pulse_stretch_chan : one channel of the pulse stretcher (IDLE/HOLD/GAP FSM).
// Build option: PULSE_STRETCHER_RETRIGGER_EN restarts HOLD on a new edge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pulse_stretch_chan
   import pulse_stretcher_pkg::*;
#(
   parameter int CNT_W    = 8,
   parameter bit IDLE_VAL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] hold_cycles,
   input  logic [CNT_W-1:0] gap_cycles,
   input  logic             data_in,
   output logic             data_out,
   output logic             busy
);

   localparam logic c_active_val = active_level(IDLE_VAL);

   ps_state_t        r_state;
   ps_state_t        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_pending;
   logic             w_pending_nxt;
   logic             r_prev;
   logic             r_out;
   logic             r_busy;
   logic             w_out_nxt;
   logic             w_busy_nxt;
   logic             w_edge;

   assign w_edge = (data_in != IDLE_VAL) && (r_prev == IDLE_VAL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_pending <= 1'b0;
         r_prev    <= IDLE_VAL;
         r_out     <= IDLE_VAL;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_pending <= w_pending_nxt;
         r_prev    <= data_in;
         r_out     <= w_out_nxt;
         r_busy    <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_pending_nxt = r_pending;
      case (r_state)
         ST_IDLE: begin
            if (w_edge) begin
               w_state_nxt = ST_HOLD;
               w_cnt_nxt   = '0;
            end
         end
         ST_HOLD: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
            // A fresh edge restarts the pulse instead of queueing another one.
            if (w_edge) begin
               w_cnt_nxt = '0;
            end else if (r_cnt >= hold_cycles) begin
               w_state_nxt = ST_GAP;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
`else
            if (w_edge) begin
               w_pending_nxt = 1'b1;
            end
            if (r_cnt >= hold_cycles) begin
               w_state_nxt = ST_GAP;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
`endif
         end
         ST_GAP: begin
            if (w_edge) begin
               w_pending_nxt = 1'b1;
            end
            if (r_cnt >= gap_cycles) begin
               w_cnt_nxt = '0;
               if (r_pending || w_edge) begin
                  w_state_nxt   = ST_HOLD;
                  w_pending_nxt = 1'b0;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = '0;
            w_pending_nxt = 1'b0;
         end
      endcase
   end

   // Outputs are registered copies of what the next state implies.
   always_comb begin
      w_out_nxt  = (w_state_nxt == ST_HOLD) ? c_active_val : IDLE_VAL;
      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   assign data_out = r_out;
   assign busy     = r_busy;

endmodule

`default_nettype wire

// File: rtl/pulse_stretcher.sv
// ============================================================================
// pulse_stretcher : multi-channel minimum-width pulse / minimum-gap conditioner.
// Build option: PULSE_STRETCHER_RETRIGGER_EN (see pulse_stretch_chan).
// Revision: 1.0
// ============================================================================
`default_nettype none

module pulse_stretcher
   import pulse_stretcher_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int CNT_W    = 8,
   parameter bit IDLE_VAL = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CNT_W-1:0]  hold_cycles,
   input  logic [CNT_W-1:0]  gap_cycles,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic [DATA_W-1:0] busy
);

   generate
      for (genvar g = 0; g < DATA_W; g++) begin : g_chan
         pulse_stretch_chan #(
            .CNT_W    (CNT_W),
            .IDLE_VAL (IDLE_VAL)
         ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .hold_cycles (hold_cycles),
            .gap_cycles  (gap_cycles),
            .data_in     (data_in[g]),
            .data_out    (data_out[g]),
            .busy        (busy[g])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
// ============================================================================
// tb_pulse_stretcher : directed bench for pulse_stretcher (default and IDLE_VAL=1).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pulse_stretcher;

   logic       clk;
   logic       rst;
   logic [7:0] hold_cycles;
   logic [7:0] gap_cycles;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic [7:0] busy;
   logic [3:0] data_in2;
   logic [3:0] data_out2;
   logic [3:0] busy2;

   int n_assert = 0;
   int n_fail   = 0;

   pulse_stretcher #(.DATA_W(8), .CNT_W(8), .IDLE_VAL(1'b0)) dut (
      .clk         (clk),
      .rst         (rst),
      .hold_cycles (hold_cycles),
      .gap_cycles  (gap_cycles),
      .data_in     (data_in),
      .data_out    (data_out),
      .busy        (busy)
   );

   pulse_stretcher #(.DATA_W(4), .CNT_W(8), .IDLE_VAL(1'b1)) dut_inv (
      .clk         (clk),
      .rst         (rst),
      .hold_cycles (hold_cycles),
      .gap_cycles  (gap_cycles),
      .data_in     (data_in2),
      .data_out    (data_out2),
      .busy        (busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, obs, exp);
      end
   endtask

   // One character per clock: drive din, then check data_out/busy after the edge.
   task automatic seq(input string tag, input string din, input string eo, input string eb,
                      input logic [7:0] mask);
      for (int i = 0; i < din.len(); i++) begin
         data_in = (din[i] == "1") ? mask : 8'h00;
         @(posedge clk);
         #1;
         check({tag, ".out"},  i, data_out, (eo[i] == "1") ? mask : 8'h00);
         check({tag, ".busy"}, i, busy,     (eb[i] == "1") ? mask : 8'h00);
      end
   endtask

   initial begin
      string eo2;
      string eb2;
      rst         = 1'b1;
      data_in     = 8'h00;
      data_in2    = 4'hF;
      hold_cycles = 8'd0;
      gap_cycles  = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.out",   0, data_out, 8'h00);
      check("rst.busy",  0, busy, 8'h00);
      check("rst.out2",  0, {4'h0, data_out2}, 8'h0F);
      check("rst.busy2", 0, {4'h0, busy2}, 8'h00);
      rst = 1'b0;

      hold_cycles = 8'd3;
      gap_cycles  = 8'd2;
      seq("single", "1000000000", "1111000000", "1111111000", 8'h01);
      seq("single7", "1000000000", "1111000000", "1111111000", 8'h80);
`ifdef PULSE_STRETCHER_RETRIGGER_EN
      seq("in_hold", "1010000000", "1111110000", "1111111110", 8'h01);
`else
      seq("in_hold", "101000000000000", "111100011110000", "111111111111110", 8'h01);
`endif

      hold_cycles = 8'd1;
      gap_cycles  = 8'd4;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
      seq("burst", "1010100000000000", "1111110000000000", "1111111111100000", 8'h01);
`else
      seq("burst", "1010100000000000", "1100000110000000", "1111111111111100", 8'h01);
`endif

      hold_cycles = 8'd0;
      gap_cycles  = 8'd0;
      seq("min_rate", "1010101000", "1010101000", "1111111100", 8'h01);
      seq("level",    "11110",      "10000",      "11000",      8'h01);
      seq("all_ch",   "100",        "100",        "110",        8'hFF);

      // Shortening the hold length mid-pulse ends HOLD on the next clock.
      hold_cycles = 8'd10;
      seq("live_a", "1000", "1111", "1111", 8'h01);
      hold_cycles = 8'd0;
      seq("live_b", "00", "00", "10", 8'h01);

      hold_cycles = 8'd10;
      seq("rst_mid", "100", "111", "111", 8'h01);
      #3;
      rst = 1'b1;
      #1;
      check("rst_async.out",  0, data_out, 8'h00);
      check("rst_async.busy", 0, busy, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      seq("post_rst", "0000", "0000", "0000", 8'h01);

      hold_cycles = 8'd1;
      gap_cycles  = 8'd0;
      #2;
      rst     = 1'b1;
      data_in = 8'h01;
      @(posedge clk);
      #1;
      rst = 1'b0;
      seq("held_rst", "11110", "11000", "11100", 8'h01);

      hold_cycles = 8'd2;
      gap_cycles  = 8'd0;
      eo2 = "00011";
      eb2 = "11110";
      data_in2 = 4'h0;
      for (int i = 0; i < eo2.len(); i++) begin
         @(posedge clk);
         #1;
         check("inv.out",  i, {4'h0, data_out2}, (eo2[i] == "1") ? 8'h0F : 8'h00);
         check("inv.busy", i, {4'h0, busy2},     (eb2[i] == "1") ? 8'h0F : 8'h00);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
